// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Sequential 8-bit unsigned restoring divider. One quotient bit is produced
// per clock, MSB first, so a division takes 8 CALC cycles plus one DONE cycle.
// A divisor of zero skips the iteration and reports a saturated result.
//
// Ports
//   clk         in   1  rising-edge clock for all state
//   reset       in   1  synchronous, active-high reset
//   start       in   1  division request, sampled only in IDLE
//   in_A        in   8  unsigned dividend, captured on an accepted start
//   in_B        in   8  unsigned divisor, captured on an accepted start
//   Quotient    out  8  registered quotient of the last completed division
//   Remainder   out  8  registered remainder of the last completed division
//   busy        out  1  high whenever the FSM is not in IDLE
//   done        out  1  one-cycle result-valid pulse (FSM in DONE)
//   div_by_zero out  1  last accepted divisor was zero
//   zero        out  1  last written Quotient equals zero
// -----------------------------------------------------------------------------
module seq_divider (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] in_A,
    input  logic [7:0] in_B,
    output logic [7:0] Quotient,
    output logic [7:0] Remainder,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero,
    output logic       zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // One restoring step. The shifted partial remainder is the 9-bit value
    // {rem, bit_in}. Its top bit is rem[7]; when that bit is set the shifted
    // value is at least 256 and therefore exceeds any 8-bit divisor. Because
    // the partial remainder is always below the divisor, the non-negative
    // difference always fits in 8 bits, so modular 8-bit subtraction of the
    // low part gives the exact kept remainder.
    // Returns {quotient_bit, new_remainder}.
    // -------------------------------------------------------------------------
    function automatic logic [8:0] restoring_step(
        input logic [7:0] rem,
        input logic       bit_in,
        input logic [7:0] divisor
    );
        logic [7:0] low;
        logic       fits;
        logic [7:0] diff;
        begin
            low  = {rem[6:0], bit_in};
            fits = rem[7] | (low >= divisor);
            diff = low - divisor;
            if (fits) begin
                restoring_step = {1'b1, diff};
            end else begin
                restoring_step = {1'b0, low};
            end
        end
    endfunction

    state_t     state_r;
    state_t     next_state_s;

    logic [7:0] dividend_r;     // shifts left, MSB feeds the next step
    logic [7:0] divisor_r;
    logic [7:0] rem_r;          // partial remainder, never visible on ports
    logic [7:0] quo_r;          // partial quotient, never visible on ports
    logic [2:0] cnt_r;

    logic [7:0] quotient_r;
    logic [7:0] remainder_r;
    logic       div_by_zero_r;
    logic       zero_r;
    logic       busy_r;
    logic       done_r;

    logic       load_s;         // accepted start with a non-zero divisor
    logic       dbz_s;          // accepted start with a zero divisor
    logic       step_s;         // perform one iteration this edge
    logic       last_s;         // final iteration, publish result

    logic [8:0] step_res_s;
    logic       step_qbit_s;
    logic [7:0] step_rem_s;
    logic [7:0] next_quo_s;

    // Combinational restoring step on the current partial values.
    always_comb begin
        step_res_s  = restoring_step(rem_r, dividend_r[7], divisor_r);
        step_qbit_s = step_res_s[8];
        step_rem_s  = step_res_s[7:0];
        next_quo_s  = {quo_r[6:0], step_qbit_s};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (in_B == 8'd0) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_CALC;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == 3'd7) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_CALC;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output/control decode of the current state.
    always_comb begin
        load_s = 1'b0;
        dbz_s  = 1'b0;
        step_s = 1'b0;
        last_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_s = (in_B != 8'd0);
                    dbz_s  = (in_B == 8'd0);
                end else begin
                    load_s = 1'b0;
                    dbz_s  = 1'b0;
                end
            end
            ST_CALC: begin
                step_s = 1'b1;
                last_s = (cnt_r == 3'd7);
            end
            ST_DONE: begin
                step_s = 1'b0;
            end
            default: begin
                step_s = 1'b0;
            end
        endcase
    end

    // Iteration datapath: operand capture and one step per CALC edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            dividend_r <= 8'd0;
            divisor_r  <= 8'd0;
            rem_r      <= 8'd0;
            quo_r      <= 8'd0;
            cnt_r      <= 3'd0;
        end else if (load_s) begin
            dividend_r <= in_A;
            divisor_r  <= in_B;
            rem_r      <= 8'd0;
            quo_r      <= 8'd0;
            cnt_r      <= 3'd0;
        end else if (step_s) begin
            dividend_r <= {dividend_r[6:0], 1'b0};
            rem_r      <= step_rem_s;
            quo_r      <= next_quo_s;
            cnt_r      <= cnt_r + 3'd1;
        end else begin
            dividend_r <= dividend_r;
            divisor_r  <= divisor_r;
            rem_r      <= rem_r;
            quo_r      <= quo_r;
            cnt_r      <= cnt_r;
        end
    end

    // Result registers: written only at completion, held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            quotient_r    <= 8'd0;
            remainder_r   <= 8'd0;
            div_by_zero_r <= 1'b0;
            zero_r        <= 1'b0;
        end else if (dbz_s) begin
            quotient_r    <= 8'hFF;
            remainder_r   <= in_A;
            div_by_zero_r <= 1'b1;
            zero_r        <= 1'b0;
        end else if (last_s) begin
            quotient_r    <= next_quo_s;
            remainder_r   <= step_rem_s;
            div_by_zero_r <= 1'b0;
            zero_r        <= (next_quo_s == 8'd0);
        end else begin
            quotient_r    <= quotient_r;
            remainder_r   <= remainder_r;
            div_by_zero_r <= div_by_zero_r;
            zero_r        <= zero_r;
        end
    end

    // Status flags registered from the next state so they track state_r exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s != ST_IDLE);
            done_r <= (next_state_s == ST_DONE);
        end
    end

    assign Quotient    = quotient_r;
    assign Remainder   = remainder_r;
    assign div_by_zero = div_by_zero_r;
    assign zero        = zero_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Directed and randomised self-checking bench for seq_divider. Inputs change
// and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] in_A;
    logic [7:0] in_B;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;
    logic       zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_A        (in_A),
        .in_B        (in_B),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .zero        (zero)
    );

    always #5 clk = ~clk;

    // Start one division at the current falling edge and wait (bounded) for done.
    // cyc counts falling edges from the start edge to the one showing done.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output int cyc, output bit timeout);
        in_A  = a;
        in_B  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        timeout = (done !== 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        in_A  = 8'd10;
        in_B  = 8'd3;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, div_by_zero, zero} !== 4'b0000 ||
            Quotient !== 8'd0 || Remainder !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b dbz=%b zero=%b Q=%0d R=%0d, expected all 0",
                     busy, done, div_by_zero, zero, Quotient, Remainder);
        end
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_start_ignored: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = -1;
        logic [7:0] q_s = 8'd0;
        logic [7:0] r_s = 8'd0;
        logic z_s = 1'b1;
        logic d_s = 1'b1;
        in_A  = 8'd100;
        in_B  = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = i;
                q_s = Quotient;
                r_s = Remainder;
                z_s = zero;
                d_s = div_by_zero;
            end
            @(negedge clk);
        end
        n_checks++;
        if (busy_cnt != 9) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: got %0d expected 9", busy_cnt);
        end
        n_checks++;
        if (done_cnt != 1 || done_at != 9) begin
            n_fail++;
            $display("FAIL basic_done_pulse: count=%0d at=%0d expected count=1 at=9", done_cnt, done_at);
        end
        n_checks++;
        if (q_s !== 8'd14 || r_s !== 8'd2 || z_s !== 1'b0 || d_s !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: Q=%0d R=%0d zero=%b dbz=%b expected Q=14 R=2 zero=0 dbz=0",
                     q_s, r_s, z_s, d_s);
        end
        n_checks++;
        if (Quotient !== 8'd14 || Remainder !== 8'd2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_hold: Q=%0d R=%0d busy=%b expected Q=14 R=2 busy=0",
                     Quotient, Remainder, busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit to;
        run_op(8'd255, 8'd1, cyc, to);
        n_checks++;
        if (to || cyc != 9 || Quotient !== 8'd255 || Remainder !== 8'd0 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_255_1: timeout=%0b cyc=%0d Q=%0d R=%0d zero=%b expected cyc=9 Q=255 R=0 zero=0",
                     to, cyc, Quotient, Remainder, zero);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle_gap: busy=%b done=%b expected 0 0", busy, done);
        end
        run_op(8'd5, 8'd9, cyc, to);
        n_checks++;
        if (to || cyc != 9 || Quotient !== 8'd0 || Remainder !== 8'd5 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_5_9: timeout=%0b cyc=%0d Q=%0d R=%0d zero=%b expected cyc=9 Q=0 R=5 zero=1",
                     to, cyc, Quotient, Remainder, zero);
        end
    endtask

    task automatic test_div_zero();
        int cyc;
        bit to;
        @(negedge clk);
        run_op(8'd37, 8'd0, cyc, to);
        n_checks++;
        if (to || cyc != 1 || Quotient !== 8'hFF || Remainder !== 8'd37 ||
            div_by_zero !== 1'b1 || zero !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL dbz_37_0: timeout=%0b cyc=%0d Q=%0h R=%0d dbz=%b zero=%b busy=%b expected cyc=1 Q=ff R=37 dbz=1 zero=0 busy=1",
                     to, cyc, Quotient, Remainder, div_by_zero, zero, busy);
        end
        @(negedge clk);
        run_op(8'd8, 8'd2, cyc, to);
        n_checks++;
        if (to || cyc != 9 || Quotient !== 8'd4 || Remainder !== 8'd0 ||
            div_by_zero !== 1'b0 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL dbz_then_8_2: timeout=%0b cyc=%0d Q=%0d R=%0d dbz=%b zero=%b expected Q=4 R=0 dbz=0 zero=0",
                     to, cyc, Quotient, Remainder, div_by_zero, zero);
        end
    endtask

    task automatic test_reset_abort();
        int done_cnt = 0;
        int busy_cnt = 0;
        @(negedge clk);
        in_A  = 8'd200;
        in_B  = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;            // first CALC cycle
        repeat (3) @(negedge clk);  // fourth CALC cycle
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, done, div_by_zero, zero} !== 4'b0000 ||
            Quotient !== 8'd0 || Remainder !== 8'd0) begin
            n_fail++;
            $display("FAIL abort_state: busy=%b done=%b dbz=%b zero=%b Q=%0d R=%0d expected all 0",
                     busy, done, div_by_zero, zero, Quotient, Remainder);
        end
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (busy === 1'b1) busy_cnt++;
        end
        n_checks++;
        if (done_cnt != 0 || busy_cnt != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: done_cnt=%0d busy_cnt=%0d expected 0 0", done_cnt, busy_cnt);
        end
    endtask

    task automatic test_ignore_start();
        int cyc = 1;
        int busy_cnt = 0;
        in_A  = 8'd90;
        in_B  = 8'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        cyc++;
        in_A  = 8'd50;
        in_B  = 8'd5;
        start = 1'b1;
        @(negedge clk);
        cyc++;
        start = 1'b0;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (done !== 1'b1 || cyc != 9 || Quotient !== 8'd22 || Remainder !== 8'd2) begin
            n_fail++;
            $display("FAIL ignore_start: done=%b cyc=%0d Q=%0d R=%0d expected done=1 cyc=9 Q=22 R=2",
                     done, cyc, Quotient, Remainder);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
        end
        n_checks++;
        if (busy_cnt != 0) begin
            n_fail++;
            $display("FAIL ignore_start_no_rerun: busy_cnt=%0d expected 0", busy_cnt);
        end
    endtask

    task automatic test_random();
        int cyc;
        bit to;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_q;
        logic [7:0] exp_r;
        logic       exp_dbz;
        logic       exp_zero;
        int         exp_cyc;
        logic [15:0] recon;
        for (int n = 0; n < 1000; n++) begin
            a = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) b = 8'd0;
            else b = 8'($urandom_range(0, 255));
            if (b == 8'd0) begin
                exp_q = 8'hFF; exp_r = a; exp_dbz = 1'b1; exp_zero = 1'b0; exp_cyc = 1;
            end else begin
                exp_q = a / b; exp_r = a % b; exp_dbz = 1'b0;
                exp_zero = (exp_q == 8'd0); exp_cyc = 9;
            end
            @(negedge clk);
            run_op(a, b, cyc, to);
            n_checks++;
            if (to || cyc != exp_cyc || Quotient !== exp_q || Remainder !== exp_r ||
                div_by_zero !== exp_dbz || zero !== exp_zero) begin
                n_fail++;
                $display("FAIL rand_%0d %0d/%0d: timeout=%0b cyc=%0d Q=%0d R=%0d dbz=%b zero=%b expected cyc=%0d Q=%0d R=%0d dbz=%b zero=%b",
                         n, a, b, to, cyc, Quotient, Remainder, div_by_zero, zero,
                         exp_cyc, exp_q, exp_r, exp_dbz, exp_zero);
            end
            if (b != 8'd0) begin
                recon = 16'(Quotient) * 16'(b) + 16'(Remainder);
                n_checks++;
                if (recon !== 16'(a) || Remainder >= b) begin
                    n_fail++;
                    $display("FAIL rand_identity_%0d %0d/%0d: Q*B+R=%0d R=%0d expected %0d with R<%0d",
                             n, a, b, recon, Remainder, a, b);
                end
            end
        end
    endtask

    // Hard stop in case the design never settles.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        in_A  = 8'd0;
        in_B  = 8'd0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_reset_abort();
        test_ignore_start();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
